// File: rtl/jc_burst_ctrl_pkg.sv
// Shared types and constants for the Johnson-counter burst sequencer.
package jc_burst_ctrl_pkg;

   localparam int unsigned JC_W = 4;

   // Terminal count (mid-period) and the last state before wrapping to 0000
   localparam logic [JC_W-1:0] JC_TC_Q   = 4'b1111;
   localparam logic [JC_W-1:0] JC_WRAP_Q = 4'b1000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   // One Johnson step: shift left, feed back the inverted MSB
   function automatic logic [JC_W-1:0] jc_next(input logic [JC_W-1:0] cur);
      return {cur[JC_W-2:0], ~cur[JC_W-1]};
   endfunction

endpackage

// File: rtl/jc4_core.sv
// 4-bit Johnson counter with synchronous reset, clock enable, TC and CEO.
module jc4_core
   import jc_burst_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            R,
   input  logic            ce,
   output logic [JC_W-1:0] q,
   output logic            tc,
   output logic            ceo
);

   // Counter register; reset wins over enable
   always_ff @(posedge clk) begin
      if (R)
         q <= '0;
      else if (ce)
         q <= jc_next(q);
   end

   assign tc  = (q == JC_TC_Q);
   assign ceo = ce & tc;

endmodule

// File: rtl/jc_burst_ctrl.sv
// Burst sequencer: clears and steps a Johnson counter for len full periods,
// with pause, abort and completion/abort pulses.
module jc_burst_ctrl
   import jc_burst_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 8
)
(
   input  logic             clk,
   input  logic             R,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             mark,
   output logic [JC_W-1:0]  q,
   output logic [CNT_W-1:0] remaining
);

   state_t state;
   logic   core_r;
   logic   core_ce;
   logic   core_tc;
   logic   core_ceo;
   logic   wrap;

   // Counter is cleared on entry to a burst and on abort; abort also blocks the step
   assign core_r  = R | (state == S_CLEAR) | (state == S_ABORT);
   assign core_ce = (state == S_RUN) & ~pause & ~abort;
   assign wrap    = core_ce & (q == JC_WRAP_Q);

   jc4_core u_core (
      .clk (clk),
      .R   (core_r),
      .ce  (core_ce),
      .q   (q),
      .tc  (core_tc),
      .ceo (core_ceo)
   );

   // Status decodes from the state register
   assign busy    = (state == S_CLEAR) | (state == S_RUN);
   assign done    = (state == S_DONE);
   assign aborted = (state == S_ABORT);
   assign mark    = core_ceo & core_tc;

   // Burst FSM and remaining-period counter
   always_ff @(posedge clk) begin
      if (R) begin
         state     <= S_IDLE;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  if (len != '0) begin
                     state     <= S_CLEAR;
                     remaining <= len;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_CLEAR: begin
               state <= abort ? S_ABORT : S_RUN;
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_ABORT;
               end else if (wrap) begin
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1))
                     state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            S_ABORT: begin
               remaining <= '0;
               state     <= S_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               remaining <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jc_burst_ctrl.sv
// Scoreboard bench for jc_burst_ctrl: expected mark/done/aborted events are
// queued at stimulus time and matched by a monitor on the falling edge.
module tb_jc_burst_ctrl;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             R;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             pause;
   logic             abort;
   logic             busy;
   logic             done;
   logic             aborted;
   logic             mark;
   logic [3:0]       q;
   logic [CNT_W-1:0] remaining;

   jc_burst_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .R         (R),
      .start     (start),
      .len       (len),
      .pause     (pause),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .mark      (mark),
      .q         (q),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   typedef enum int {EV_MARK = 0, EV_DONE = 1, EV_ABORT = 2} ev_kind_t;
   typedef struct {
      ev_kind_t         kind;
      int               t;
      logic [3:0]       q;
      logic [CNT_W-1:0] rem;
   } ev_t;

   ev_t exp_q[$];

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
   endtask

   task automatic push_ev(input ev_kind_t k, input int t, input logic [3:0] eq, input int rem);
      ev_t e;
      e.kind = k;
      e.t    = t;
      e.q    = eq;
      e.rem  = CNT_W'(rem);
      exp_q.push_back(e);
   endtask

   // Unpaused burst: mark mid-period with the pre-wrap remaining, done 8*L+2
   task automatic push_burst(input int t0, input int l);
      for (int k = 0; k < l; k++)
         push_ev(EV_MARK, t0 + 6 + 8*k, 4'b1111, l - k);
      push_ev(EV_DONE, t0 + 8*l + 2, 4'b0000, 0);
   endtask

   // Land 1 time unit after the rising edge that starts cycle t
   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Land on the falling edge inside cycle t
   task automatic goto_mid(input int t);
      goto(t);
      @(negedge clk);
   endtask

   // Monitor: every output pulse must match the head of the expected queue
   always @(negedge clk) begin
      ev_kind_t k;
      ev_t      e;
      if (mark || done || aborted) begin
         k = done ? EV_DONE : (aborted ? EV_ABORT : EV_MARK);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", int'(k), -1);
         end else begin
            e = exp_q.pop_front();
            chk("ev_kind",  int'(k),   int'(e.kind));
            chk("ev_cycle", cyc,       e.t);
            chk("ev_q",     int'(q),   int'(e.q));
            chk("ev_rem",   int'(remaining), int'(e.rem));
         end
      end
   end

   logic [3:0] seq [8];
   int t0;
   int t1;

   initial begin
      seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      R = 1'b1; start = 1'b0; len = '0; pause = 1'b0; abort = 1'b0;
      goto(3);
      R = 1'b0;
      goto_mid(3);
      chk("rst_q",       int'(q), 0);
      chk("rst_rem",     int'(remaining), 0);
      chk("rst_busy",    int'(busy), 0);
      chk("rst_done",    int'(done), 0);
      chk("rst_aborted", int'(aborted), 0);
      chk("rst_mark",    int'(mark), 0);

      // len=1: full q sequence, mark at 6, done at 10
      goto(cyc + 1);
      t0 = cyc; start = 1'b1; len = CNT_W'(1);
      push_burst(t0, 1);
      goto(t0 + 1); start = 1'b0;
      goto_mid(t0 + 1);
      chk("t1_busy_clear", int'(busy), 1);
      for (int k = 0; k < 8; k++) begin
         goto_mid(t0 + 2 + k);
         chk("t1_q_seq", int'(q), int'(seq[k]));
      end
      chk("t1_rem_before_wrap", int'(remaining), 1);
      goto(t0 + 12);

      // len=3 with pause in cycles 5..7
      t0 = cyc; start = 1'b1; len = CNT_W'(3);
      push_ev(EV_MARK, t0 + 9,  4'b1111, 3);
      push_ev(EV_MARK, t0 + 17, 4'b1111, 2);
      push_ev(EV_MARK, t0 + 25, 4'b1111, 1);
      push_ev(EV_DONE, t0 + 29, 4'b0000, 0);
      goto(t0 + 1); start = 1'b0;
      goto(t0 + 5); pause = 1'b1;
      for (int k = 5; k <= 7; k++) begin
         goto_mid(t0 + k);
         chk("t2_pause_hold", int'(q), 4'b0111);
      end
      goto(t0 + 8); pause = 1'b0;
      goto(t0 + 31);

      // len=4 with abort in cycle 12
      t0 = cyc; start = 1'b1; len = CNT_W'(4);
      push_ev(EV_MARK,  t0 + 6,  4'b1111, 4);
      push_ev(EV_ABORT, t0 + 13, 4'b0011, 3);
      goto(t0 + 1);  start = 1'b0;
      goto(t0 + 12); abort = 1'b1;
      goto(t0 + 13); abort = 1'b0;
      goto_mid(t0 + 14);
      chk("t3_q_after_abort",    int'(q), 0);
      chk("t3_rem_after_abort",  int'(remaining), 0);
      chk("t3_busy_after_abort", int'(busy), 0);
      goto(t0 + 20);

      // len=0: immediate done, no busy, counter idle
      t0 = cyc; start = 1'b1; len = '0;
      push_ev(EV_DONE, t0 + 1, 4'b0000, 0);
      goto(t0 + 1); start = 1'b0;
      goto_mid(t0 + 1);
      chk("t4_busy_len0", int'(busy), 0);
      goto_mid(t0 + 2);
      chk("t4_busy_after", int'(busy), 0);
      chk("t4_q_idle",     int'(q), 0);
      goto(t0 + 4);

      // len=2 with start pulsed during RUN and during DONE
      t0 = cyc; start = 1'b1; len = CNT_W'(2);
      push_burst(t0, 2);
      goto(t0 + 1);  start = 1'b0;
      goto(t0 + 4);  start = 1'b1; len = CNT_W'(5);
      goto(t0 + 5);  start = 1'b0;
      goto_mid(t0 + 5);
      chk("t5_rem_unchanged", int'(remaining), 2);
      goto(t0 + 18); start = 1'b1;
      goto(t0 + 19); start = 1'b0;
      goto_mid(t0 + 20);
      chk("t5_busy_after_done", int'(busy), 0);
      chk("t5_rem_after_done",  int'(remaining), 0);
      goto(t0 + 32);

      // Reset mid-burst at q=0111, then a normal len=1 burst
      t0 = cyc; start = 1'b1; len = CNT_W'(2);
      goto(t0 + 1); start = 1'b0;
      goto(t0 + 5); R = 1'b1;
      goto_mid(t0 + 5);
      chk("t6_q_before_rst", int'(q), 4'b0111);
      goto(t0 + 6); R = 1'b0;
      goto_mid(t0 + 6);
      chk("t6_q",       int'(q), 0);
      chk("t6_busy",    int'(busy), 0);
      chk("t6_done",    int'(done), 0);
      chk("t6_aborted", int'(aborted), 0);
      chk("t6_mark",    int'(mark), 0);
      chk("t6_rem",     int'(remaining), 0);
      goto(t0 + 7);
      t1 = cyc; start = 1'b1; len = CNT_W'(1);
      push_burst(t1, 1);
      goto(t1 + 1); start = 1'b0;
      goto(t1 + 14);

      chk("leftover_events", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
